// File: rtl/morph_line_ctrl.sv
// morph_line_ctrl: frame/line sequencer for the 3x3 dilate/erode datapath driven by VGA scan coordinates.
module morph_line_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW = 10,
  parameter int YW = 10
) (
  input  logic          vga_clk,
  input  logic          rst_n,
  input  logic [XW-1:0] i_pixel_x,
  input  logic [YW-1:0] i_pixel_y,
  input  logic          i_enable,
  input  logic          i_cfg_valid,
  input  logic [1:0]    i_cfg_mode,
  output logic          o_cfg_ready,
  output logic [1:0]    o_mode_active,
  output logic          o_wr_en,
  output logic          o_wr_bank,
  output logic [XW-1:0] o_wr_addr,
  output logic [XW-1:0] o_rd_addr_m2,
  output logic [XW-1:0] o_rd_addr_m1,
  output logic          o_win_valid,
  output logic          o_frame_done,
  output logic          o_busy
);
  typedef enum logic [2:0] {IDLE, ARMED, FILL, RUN, DONE} state_t;
  state_t        r_state, w_nxt;
  logic [XW-1:0] r_px_prev, r_wr_addr, r_rd_m2, r_rd_m1;
  logic          r_bank, r_wr_en, r_win, r_pend;
  logic [1:0]    r_pend_mode, r_mode;
  logic          w_active, w_line_start, w_frame_start, w_last;
  logic          w_start_fill, w_run_px, w_proc_px, w_bank;
  assign w_active      = (i_pixel_x < XW'(H_ACTIVE)) && (i_pixel_y < YW'(V_ACTIVE));
  assign w_line_start  = w_active && (i_pixel_x == '0) && (r_px_prev != '0);
  assign w_frame_start = w_line_start && (i_pixel_y == '0);
  assign w_last        = (i_pixel_y == YW'(V_ACTIVE - 1)) && (i_pixel_x == XW'(H_ACTIVE - 1));
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = i_enable ? ARMED : IDLE;
      ARMED:   w_nxt = w_frame_start ? (i_enable ? FILL : IDLE) : ARMED;
      FILL:    w_nxt = (w_line_start && i_pixel_y == YW'(2)) ? RUN : FILL;
      RUN:     w_nxt = w_last ? DONE : RUN;
      DONE:    w_nxt = i_enable ? ARMED : IDLE;
      default: w_nxt = IDLE;
    endcase
    // the pixel that triggers a transition belongs to the state being entered, except the last RUN pixel
    w_start_fill = (r_state == ARMED) && w_frame_start && i_enable;
    w_run_px     = (w_nxt == RUN) || (r_state == RUN);
    w_proc_px    = w_run_px || (w_nxt == FILL);
    w_bank       = w_frame_start ? 1'b0 : (w_line_start && w_proc_px) ? ~r_bank : r_bank;
  end
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_px_prev   <= '0;
      r_bank      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_m2     <= '0;
      r_rd_m1     <= '0;
      r_win       <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_mode <= 2'b00;
      r_mode      <= 2'b00;
    end else begin
      r_state   <= w_nxt;
      r_px_prev <= i_pixel_x;
      r_bank    <= w_bank;
      r_wr_en   <= w_active && w_proc_px;
      r_wr_addr <= i_pixel_x;
      r_rd_m2   <= i_pixel_x - XW'(2);
      r_rd_m1   <= i_pixel_x - XW'(1);
      r_win     <= w_run_px && w_active && (i_pixel_x >= XW'(2));
      if (w_start_fill && r_pend) begin
        r_mode <= r_pend_mode;
        r_pend <= 1'b0;
      end else if (i_cfg_valid && !r_pend) begin
        r_pend      <= 1'b1;
        r_pend_mode <= (&i_cfg_mode) ? 2'b00 : i_cfg_mode;
      end
    end
  end
  assign o_cfg_ready   = ~r_pend;
  assign o_mode_active = r_mode;
  assign o_wr_en       = r_wr_en;
  assign o_wr_bank     = r_bank;
  assign o_wr_addr     = r_wr_addr;
  assign o_rd_addr_m2  = r_rd_m2;
  assign o_rd_addr_m1  = r_rd_m1;
  assign o_win_valid   = r_win;
  assign o_frame_done  = (r_state == DONE);
  assign o_busy        = (r_state == FILL) || (r_state == RUN);
endmodule
